aes_inv_key_sched: RTL and testbench
====================================

# aes_inv_key_sched

Iterative AES-128 inverse key schedule. It takes the final round key K10 and walks the key expansion backwards, emitting K10, K9, … K0, one key per accepted transfer. It feeds the decryption datapath, which consumes round keys in reverse order. It is the sequential counterpart of the combinational forward key expansion (GenRoundKeys): that block builds K1..K10 from K0, and this block recovers K9..K0 from K10.

## Interface

Parameters: none.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1. Asynchronous, active-high reset. One clock domain.
- start, input, 1. Request to begin a schedule. Sampled only in IDLE.
- key_in, input, 128. Final round key K10. Word w0 = [127:96], w3 = [31:0].
- busy, output, 1. High from the cycle after start is accepted until done.
- key_valid, output, 1. round_key and round_idx are valid.
- key_ready, input, 1. Consumer accepts the key when key_valid && key_ready.
- round_key, output, 128. Current round key K[round_idx].
- round_idx, output, 4. Round number of round_key, 10 down to 0.
- done, output, 1. One-cycle pulse after K0 is accepted.
- rd_idx, input, 4. Store read index. Only with AES_INV_KEY_STORE_EN.
- rd_key, output, 128. Stored key. Only with AES_INV_KEY_STORE_EN.
- keys_ready, output, 1. All 11 keys stored. Only with AES_INV_KEY_STORE_EN.

## Operation

States:
- IDLE → EMIT when start = 1. key_in is captured into the key register, and round_idx is set to 10.
- EMIT: key_valid = 1.
  - On accept with round_idx > 0: the key register is loaded with the previous round key, and round_idx decrements.
  - On accept with round_idx = 0: go to DONE.
  - Without accept: all outputs hold stable.
- DONE: done = 1 and key_valid = 0 for one cycle, then IDLE.

Previous-key arithmetic, given K_r = (w0, w1, w2, w3):
- w3' = w3 ^ w2
- w2' = w2 ^ w1
- w1' = w1 ^ w0
- w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[r], 24'h0}
- RotWord is a left byte rotate. SubWord is four instances of the forward AES S-box.
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. The Rcon is selected from round_idx.

Boundary rules:
- start while busy or in DONE is ignored. The in-flight schedule is unaffected.
- key_in is sampled only at start acceptance. Later changes have no effect.
- key_ready held low stalls indefinitely with no state change.
- rst asserted mid-schedule aborts immediately. No done pulse is produced.
- Reset values: busy = 0, key_valid = 0, done = 0, round_key = 0, round_idx = 0, keys_ready = 0. All store entries are cleared to 0.

## Timing

- start sampled high in IDLE at edge t → busy = 1, key_valid = 1, round_key = K10, round_idx = 10 at t+1.
- Each accept at edge t presents the next key at t+1 (1-cycle latency). The S-box path is combinational between key register outputs and next-key logic.
- Continuous key_ready = 1: K10..K0 occupy 11 consecutive cycles, done at cycle 12 after start, and IDLE at cycle 13. A new start is accepted there.
- done and the final busy = 1 coincide in the DONE cycle. busy falls together with the return to IDLE.

## Configuration

AES_INV_KEY_STORE_EN

When defined, the block includes an 11 × 128 key store and the rd_idx / rd_key / keys_ready ports:
- Entry r is written on the accept of K_r.
- keys_ready sets on the cycle after K0's accept, concurrent with done.
- keys_ready clears on the next accepted start.
- rd_key = store[rd_idx] combinationally.
- rd_idx > 10 returns 128'h0.

When not defined, there is no store and the three ports do not exist. The block is streaming only, and behaviour is otherwise identical.

## Test plan

- FIPS-197 vector: key_in = d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready = 1.
  - round_idx 10..0 appear on consecutive cycles.
  - idx 1 = a0fafe1788542cb123a339392a6c7605.
  - idx 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - done pulses once at cycle 12.
- Backpressure: same vector, with key_ready toggled pseudo-randomly and held low for 5 cycles at idx 6.
  - The sequence is identical to the first test.
  - round_key and round_idx are stable while stalled.
- Round trip: drive K10 from the forward expansion of K0 = 6e6d6f73706d6f73636d6f73766c7369.
  - Every emitted K_r matches the forward K_r.
  - The final key equals that K0.
- start pulses at idx 7 with a different key_in → ignored; the original sequence completes unchanged.
- rst asserted while round_idx = 4 → all outputs return to their reset values immediately, no done pulse. A subsequent start runs a full, correct schedule.
- With AES_INV_KEY_STORE_EN: after the FIPS run, keys_ready = 1.
  - rd_idx 0 → 2b7e1516…4f3c, rd_idx 10 → d014f9a8…0ca6, rd_idx 15 → 0.
  - A new start clears keys_ready on the next cycle.

Source files
------------

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 inverse key schedule: walks K10 back to K0, one key per accepted transfer.
// Optional 11-entry key store enabled by defining AES_INV_KEY_STORE_EN.
module aes_inv_key_sched (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         key_valid,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         done
`ifdef AES_INV_KEY_STORE_EN
    ,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key,
    output logic         keys_ready
`endif
);

    typedef enum logic [1:0] {StIdle, StEmit, StDone} state_e;

    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    state_e       state;
    logic         accept;
    logic [7:0]   rcon;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  n0, n1, n2, n3;
    logic [31:0]  rot;
    logic [127:0] prev_key;

    assign accept = (state == StEmit) && key_ready;

    always_comb begin
        unique case (round_idx)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Undo one expansion step: recover w3'..w1' by XOR, then w0' through the S-box path.
    always_comb begin
        {w0, w1, w2, w3} = round_key;
        n3       = w3 ^ w2;
        n2       = w2 ^ w1;
        n1       = w1 ^ w0;
        rot      = {n3[23:0], n3[31:24]};
        n0       = w0 ^ {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                      ^ {rcon, 24'h0};
        prev_key = {n0, n1, n2, n3};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            busy      <= 1'b0;
            key_valid <= 1'b0;
            done      <= 1'b0;
            round_key <= '0;
            round_idx <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StEmit;
                        busy      <= 1'b1;
                        key_valid <= 1'b1;
                        round_key <= key_in;
                        round_idx <= 4'd10;
                    end
                end
                StEmit: begin
                    if (accept) begin
                        if (round_idx != 4'd0) begin
                            round_key <= prev_key;
                            round_idx <= round_idx - 4'd1;
                        end else begin
                            state     <= StDone;
                            key_valid <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef AES_INV_KEY_STORE_EN
    logic [127:0] store [0:10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            keys_ready <= 1'b0;
            for (int i = 0; i < 11; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (state == StIdle && start) begin
                keys_ready <= 1'b0;
            end
            if (accept) begin
                store[round_idx] <= round_key;
                if (round_idx == 4'd0) begin
                    keys_ready <= 1'b1;
                end
            end
        end
    end

    assign rd_key = (rd_idx <= 4'd10) ? store[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Randomised bench for aes_inv_key_sched against a forward key-expansion reference model.
// Store checks are compiled in when AES_INV_KEY_STORE_EN is defined.
module tb_aes_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy, key_valid, done;
    logic         key_ready = 1'b0;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic [3:0]   rd_idx = '0;
    logic [127:0] rd_key;
    logic         keys_ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   sb_tab [256];
    logic [127:0] exp_keys [0:10];

    localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes_inv_key_sched dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .done      (done)
`ifdef AES_INV_KEY_STORE_EN
        ,
        .rd_idx    (rd_idx),
        .rd_key    (rd_key),
        .keys_ready(keys_ready)
`endif
    );

`ifndef AES_INV_KEY_STORE_EN
    assign rd_key     = '0;
    assign keys_ready = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference S-box built from GF(2^8) inversion and the affine map.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                        ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sb_tab[v[31:24]], sb_tab[v[23:16]], sb_tab[v[15:8]], sb_tab[v[7:0]]};
    endfunction

    // Standard forward expansion K0 -> K0..K10.
    task automatic expand(input logic [127:0] k0);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        {w[0], w[1], w[2], w[3]} = k0;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) begin
            exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        step();
        start  = 1'b0;
        key_in = rand128();
`ifdef AES_INV_KEY_STORE_EN
        check("keys_ready_clear", 136'(keys_ready), 136'(1'b0));
`endif
    endtask

    // mode 0: always ready; 1: random stalls, 5-cycle stall at idx 6;
    // 2: spurious start at idx 7; 3: reset at idx 4.
    task automatic walk(input int mode);
        for (int r = 10; r >= 0; r--) begin
            int stalls = 0;
            logic [135:0] want = {1'b0, 1'b1, 1'b1, 1'b0, 4'(r), exp_keys[r]};
            check($sformatf("emit_k%0d", r),
                  {1'b0, busy, key_valid, done, round_idx, round_key}, want);
            if (mode == 3 && r == 4) begin
                rst = 1'b1;
                #2;
                check("rst_async", {1'b0, busy, key_valid, done, round_idx, round_key}, '0);
                step();
                rst = 1'b0;
                step();
                check("rst_no_done", {busy, key_valid, done, keys_ready}, 136'(0));
                return;
            end
            if (mode == 1) stalls = (r == 6) ? 5 : int'($urandom_range(0, 2));
            for (int s = 0; s < stalls; s++) begin
                key_ready = 1'b0;
                step();
                check($sformatf("hold_k%0d", r),
                      {1'b0, busy, key_valid, done, round_idx, round_key}, want);
            end
            key_ready = 1'b1;
            if (mode == 2 && r == 7) start = 1'b1;
            step();
            start = 1'b0;
        end
        key_ready = 1'($urandom_range(0, 1));
        check("done_cycle", {busy, key_valid, done}, 136'(3'b101));
`ifdef AES_INV_KEY_STORE_EN
        check("keys_ready_set", 136'(keys_ready), 136'(1'b1));
`endif
        step();
        check("idle_after", {busy, key_valid, done}, 136'(0));
    endtask

    task automatic run_fips(input int mode);
        expand(FIPS_K0);
        exp_keys[10] = FIPS_K10;
        exp_keys[1]  = FIPS_K1;
        exp_keys[0]  = FIPS_K0;
        do_start(FIPS_K10);
        walk(mode);
    endtask

    initial begin
        build_sbox();
        step();
        step();
        check("reset_state", {busy, key_valid, done, keys_ready, round_idx, round_key},
              '0);
`ifdef AES_INV_KEY_STORE_EN
        rd_idx = 4'd3;
        #1;
        check("reset_store", 136'(rd_key), 136'(0));
`endif
        rst = 1'b0;
        step();

        run_fips(0);
`ifdef AES_INV_KEY_STORE_EN
        check("store_ready", 136'(keys_ready), 136'(1'b1));
        rd_idx = 4'd0;
        #1;
        check("store_rd0", 136'(rd_key), 136'(FIPS_K0));
        rd_idx = 4'd10;
        #1;
        check("store_rd10", 136'(rd_key), 136'(FIPS_K10));
        rd_idx = 4'd1;
        #1;
        check("store_rd1", 136'(rd_key), 136'(FIPS_K1));
        rd_idx = 4'd15;
        #1;
        check("store_rd15", 136'(rd_key), 136'(0));
`endif
        run_fips(1);

        expand(128'h6e6d6f73706d6f73636d6f73766c7369);
        do_start(exp_keys[10]);
        walk(0);

        run_fips(2);

        run_fips(3);
        expand(rand128());
        do_start(exp_keys[10]);
        walk(1);

        for (int n = 0; n < 4; n++) begin
            expand(rand128());
            do_start(exp_keys[10]);
            walk(n % 2);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
